// File: rtl/dbus_wb_master_if.sv
// Wishbone B4 classic single-master bus bundle between the data-bus bridge
// and the peripheral fabric slave port.
interface dbus_wb_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/dbus_wb_master.sv
// Core data-bus to Wishbone classic bridge: one single-beat cycle per core
// request, with a watchdog that turns a silent slave into an err pulse.
module dbus_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 rstn,
  input  logic                 stb,
  input  logic [3:0]           we,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 ack,
  output logic                 err,
  output logic                 busy,
  dbus_wb_master_if.master     wb
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam bit        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [31:0] rdata_reg, adr_reg, dat_reg;
  logic [3:0]  sel_reg, sel_req;
  logic        cyc_reg, we_o_reg, ack_reg, err_reg;
  logic        accept, done_ack, done_err, timeout_hit;
  logic        unused_addr;

  // Sub-word alignment is carried entirely by the byte enables.
  assign unused_addr = ^addr[1:0];

  // Reads fetch the full word; writes select only the enabled lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sel
    assign sel_req[gi] = (|we) ? we[gi] : 1'b1;
  end

  assign timeout_hit = TO_EN && (cnt_reg == TO_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    done_ack   = 1'b0;
    done_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (stb) begin
          accept     = 1'b1;
          cnt_next   = 16'd0;
          state_next = BUS;
        end
      end
      BUS: begin
        // A slave termination in the final watchdog cycle still wins.
        if (wb.wbm_err_i) begin
          done_err   = 1'b1;
          state_next = IDLE;
        end else if (wb.wbm_ack_i) begin
          done_ack   = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          done_err   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      rdata_reg <= 32'd0;
      adr_reg   <= 32'd0;
      dat_reg   <= 32'd0;
      sel_reg   <= 4'd0;
      cyc_reg   <= 1'b0;
      we_o_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= done_ack;
      err_reg   <= done_err;
      if (accept) begin
        adr_reg  <= {addr[31:2], 2'b00};
        dat_reg  <= wdata;
        sel_reg  <= sel_req;
        we_o_reg <= |we;
        cyc_reg  <= 1'b1;
      end
      if (done_ack || done_err) begin
        cyc_reg  <= 1'b0;
        we_o_reg <= 1'b0;
        sel_reg  <= 4'd0;
      end
      if (done_ack && !we_o_reg) begin
        rdata_reg <= wb.wbm_dat_i;
      end
    end
  end

  assign rdata        = rdata_reg;
  assign ack          = ack_reg;
  assign err          = err_reg;
  assign busy         = (state_reg == BUS);
  assign wb.wbm_cyc_o = cyc_reg;
  assign wb.wbm_stb_o = cyc_reg;
  assign wb.wbm_we_o  = we_o_reg;
  assign wb.wbm_sel_o = sel_reg;
  assign wb.wbm_adr_o = adr_reg;
  assign wb.wbm_dat_o = dat_reg;

endmodule

// File: tb/tb_dbus_wb_master.sv
// Bench for dbus_wb_master: instance 0 has a 4-cycle watchdog, instance 1 has
// the watchdog disabled; directed table, corner sequences, then random traffic.
module tb_dbus_wb_master;

  logic wb_clk_i = 1'b0;
  logic rstn     = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  logic        stb_s  [2];
  logic [3:0]  we_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s[2];
  logic [31:0] rdata_s[2];
  logic        ack_s  [2];
  logic        err_s  [2];
  logic        busy_s [2];
  logic        cyc_s  [2];
  logic        stbo_s [2];
  logic        weo_s  [2];
  logic [3:0]  sel_s  [2];
  logic [31:0] adr_s  [2];
  logic [31:0] dato_s [2];
  logic        acki_s [2];
  logic        erri_s [2];
  logic [31:0] dati_s [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    dbus_wb_master_if bus ();
    assign cyc_s[gi]         = bus.wbm_cyc_o;
    assign stbo_s[gi]        = bus.wbm_stb_o;
    assign weo_s[gi]         = bus.wbm_we_o;
    assign sel_s[gi]         = bus.wbm_sel_o;
    assign adr_s[gi]         = bus.wbm_adr_o;
    assign dato_s[gi]        = bus.wbm_dat_o;
    assign bus.wbm_ack_i     = acki_s[gi];
    assign bus.wbm_err_i     = erri_s[gi];
    assign bus.wbm_dat_i     = dati_s[gi];

    dbus_wb_master #(.TIMEOUT_CYCLES((gi == 0) ? 4 : 0)) dut (
      .wb_clk_i (wb_clk_i),
      .rstn     (rstn),
      .stb      (stb_s[gi]),
      .we       (we_s[gi]),
      .addr     (addr_s[gi]),
      .wdata    (wdata_s[gi]),
      .rdata    (rdata_s[gi]),
      .ack      (ack_s[gi]),
      .err      (err_s[gi]),
      .busy     (busy_s[gi]),
      .wb       (bus.master)
    );
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // rt: 0 = ack only, 1 = err only, 2 = ack and err together. k = 0: slave silent.
  task automatic run_check(input int idx, input string nm,
                           input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                           input int k, input int rt, input logic [31:0] sd, input bit busy_stb,
                           input bit e_ack, input bit e_err, input int e_cyc,
                           input logic [31:0] e_rd, input logic [3:0] e_sel,
                           input logic e_weo, input logic [31:0] e_adr);
    int c;
    @(negedge wb_clk_i);
    stb_s[idx] = 1'b1; we_s[idx] = w; addr_s[idx] = a; wdata_s[idx] = d;
    @(negedge wb_clk_i);
    stb_s[idx] = 1'b0; we_s[idx] = 4'($urandom); addr_s[idx] = $urandom; wdata_s[idx] = $urandom;
    c = 0;
    while (cyc_s[idx] && c < 400) begin
      c++;
      if (c == 1) begin
        check({nm, ".sel"},  32'(sel_s[idx]), 32'(e_sel));
        check({nm, ".we_o"}, 32'(weo_s[idx]), 32'(e_weo));
        check({nm, ".adr"},  adr_s[idx], e_adr);
        check({nm, ".dat_o"}, dato_s[idx], d);
        check({nm, ".stb_o"}, 32'(stbo_s[idx]), 32'd1);
        check({nm, ".busy"}, 32'(busy_s[idx]), 32'd1);
      end
      if (busy_stb && c == 2) begin
        stb_s[idx] = 1'b1; we_s[idx] = 4'($urandom); addr_s[idx] = $urandom;
      end
      dati_s[idx] = $urandom;
      if (c == k) begin
        acki_s[idx] = (rt != 1);
        erri_s[idx] = (rt != 0);
        dati_s[idx] = sd;
      end
      @(negedge wb_clk_i);
      acki_s[idx] = 1'b0; erri_s[idx] = 1'b0; stb_s[idx] = 1'b0;
    end
    check({nm, ".cyc_cycles"}, 32'(c), 32'(e_cyc));
    check({nm, ".ack"}, 32'(ack_s[idx]), 32'(e_ack));
    check({nm, ".err"}, 32'(err_s[idx]), 32'(e_err));
    check({nm, ".rdata"}, rdata_s[idx], e_rd);
    check({nm, ".idle_sel"}, {27'd0, busy_s[idx], sel_s[idx]}, 32'd0);
    @(negedge wb_clk_i);
    check({nm, ".pulse_end"}, {29'd0, ack_s[idx], err_s[idx], cyc_s[idx]}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  w;
    logic [31:0] a, d;
    int          k, rt;
    logic [31:0] sd;
    bit          bstb;
    bit          e_ack, e_err;
    int          e_cyc;
    logic [31:0] e_rd;
    logic [3:0]  e_sel;
    logic        e_weo;
    logic [31:0] e_adr;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] mrd[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      stb_s[i] = 0; we_s[i] = 0; addr_s[i] = 0; wdata_s[i] = 0;
      acki_s[i] = 0; erri_s[i] = 0; dati_s[i] = 0;
    end
    //          w     a             d             k  rt sd            bstb ack err cyc rdata         sel  weo adr
    tbl[0] = '{4'h0, 32'h30008005, 32'h0,        1, 0, 32'hDEADBEEF, 0, 1, 0, 1, 32'hDEADBEEF, 4'hF, 0, 32'h30008004};
    tbl[1] = '{4'h4, 32'h30008010, 32'h00AB0000, 4, 0, 32'hFFFFFFFF, 1, 1, 0, 4, 32'hDEADBEEF, 4'h4, 1, 32'h30008010};
    tbl[2] = '{4'h0, 32'h30000020, 32'h0,        2, 2, 32'h12345678, 0, 0, 1, 2, 32'hDEADBEEF, 4'hF, 0, 32'h30000020};
    tbl[3] = '{4'h0, 32'h30000033, 32'h0,        0, 0, 32'h0,        1, 0, 1, 4, 32'hDEADBEEF, 4'hF, 0, 32'h30000030};
    tbl[4] = '{4'h0, 32'h30000040, 32'h0,        4, 0, 32'hCAFEF00D, 0, 1, 0, 4, 32'hCAFEF00D, 4'hF, 0, 32'h30000040};
    tbl[5] = '{4'h0, 32'h30000044, 32'h0,        5, 0, 32'h55555555, 0, 0, 1, 4, 32'hCAFEF00D, 4'hF, 0, 32'h30000044};
    tbl[6] = '{4'h0, 32'h30000048, 32'h0,        1, 0, 32'h11223344, 0, 1, 0, 1, 32'h11223344, 4'hF, 0, 32'h30000048};
    tbl[7] = '{4'hF, 32'h3000004E, 32'h87654321, 3, 1, 32'h99999999, 0, 0, 1, 3, 32'h11223344, 4'hF, 1, 32'h3000004C};

    repeat (3) @(negedge wb_clk_i);
    for (int i = 0; i < 2; i++) begin
      check("reset.rdata", rdata_s[i], 32'd0);
      check("reset.flags", {26'd0, ack_s[i], err_s[i], busy_s[i], cyc_s[i], stbo_s[i], weo_s[i]}, 32'd0);
      check("reset.sel", 32'(sel_s[i]), 32'd0);
      check("reset.adr", adr_s[i], 32'd0);
      check("reset.dat_o", dato_s[i], 32'd0);
    end
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_check(0, $sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].k, tbl[i].rt,
                tbl[i].sd, tbl[i].bstb, tbl[i].e_ack, tbl[i].e_err, tbl[i].e_cyc, tbl[i].e_rd,
                tbl[i].e_sel, tbl[i].e_weo, tbl[i].e_adr);
    end

    run_check(1, "no_timeout", 4'h0, 32'h30000100, 32'h0, 300, 0, 32'h13579BDF, 0,
              1, 0, 300, 32'h13579BDF, 4'hF, 0, 32'h30000100);

    // Back-to-back: read strobe lands in the write's ack cycle.
    @(negedge wb_clk_i);
    stb_s[0] = 1; we_s[0] = 4'hF; addr_s[0] = 32'h00000100; wdata_s[0] = 32'hA5A5A5A5;
    @(negedge wb_clk_i);
    stb_s[0] = 0;
    check("b2b.wr_cyc", 32'(cyc_s[0]), 32'd1);
    acki_s[0] = 1;
    @(negedge wb_clk_i);
    acki_s[0] = 0;
    check("b2b.wr_ack", {30'd0, ack_s[0], cyc_s[0]}, 32'h2);
    stb_s[0] = 1; we_s[0] = 4'h0; addr_s[0] = 32'h00000104;
    @(negedge wb_clk_i);
    stb_s[0] = 0;
    check("b2b.rd_cyc", {30'd0, cyc_s[0], weo_s[0]}, 32'h2);
    check("b2b.rd_adr", adr_s[0], 32'h00000104);
    acki_s[0] = 1; dati_s[0] = 32'h0BADF00D;
    @(negedge wb_clk_i);
    acki_s[0] = 0;
    check("b2b.rd_ack", {30'd0, ack_s[0], cyc_s[0]}, 32'h2);
    check("b2b.rdata", rdata_s[0], 32'h0BADF00D);

    // Reset in the middle of a read.
    @(negedge wb_clk_i);
    stb_s[0] = 1; we_s[0] = 4'h0; addr_s[0] = 32'h30000200;
    @(negedge wb_clk_i);
    stb_s[0] = 0;
    check("rst_mid.cyc_before", 32'(cyc_s[0]), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid.flags", {26'd0, ack_s[0], err_s[0], busy_s[0], cyc_s[0], stbo_s[0], weo_s[0]}, 32'd0);
    check("rst_mid.rdata", rdata_s[0], 32'd0);
    check("rst_mid.sel", 32'(sel_s[0]), 32'd0);
    check("rst_mid.adr", adr_s[0], 32'd0);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_mid.no_term", {30'd0, ack_s[0], err_s[0]}, 32'd0);
    rstn = 1'b1;
    mrd[0] = 32'd0;
    mrd[1] = 32'd0;

    // Random traffic against the outcome model.
    for (int i = 0; i < 60; i++) begin
      int          idx, k, rt, t, e_cyc;
      bit          tmo, e_err, bstb;
      logic [3:0]  w;
      logic [31:0] a, d, sd;
      idx  = (i < 45) ? 0 : 1;
      t    = (idx == 0) ? 4 : 0;
      w    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      a    = $urandom; d = $urandom; sd = $urandom;
      k    = (idx == 0) ? $urandom_range(0, 6) : $urandom_range(1, 8);
      rt   = $urandom_range(0, 2);
      bstb = 1'($urandom_range(0, 1));
      tmo   = (t != 0) && (k == 0 || k > t);
      e_cyc = tmo ? t : k;
      e_err = tmo || (rt != 0);
      if (!e_err && w == 4'h0) mrd[idx] = sd;
      run_check(idx, $sformatf("rnd%0d", i), w, a, d, k, rt, sd, bstb, !e_err, e_err, e_cyc,
                mrd[idx], (w == 4'h0) ? 4'hF : w, (w != 4'h0), a & 32'hFFFFFFFC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_wb_master.md
# dbus_wb_master

Wishbone classic initiator that turns the core's single-beat data-bus requests (stb/we/addr/wdata → rdata/ack/err) into Wishbone B4 classic single read/write cycles. It drives the peripheral slave port of the user-area Wishbone fabric, so core loads and stores outside the data RAM window reach peripherals. It is the master end of the protocol the fabric serves as a slave. A bus-timeout watchdog converts unresponsive slaves into core-visible errors.

## Interface
- TIMEOUT_CYCLES, 255: max cycles cyc_o may stay high waiting for a response; 0 disables the timeout; legal range 0..65535.
- wb_clk_i  in  1  single clock; all state changes on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- stb  in  1  core request strobe; single-cycle pulse, sampled only in IDLE.
- we  in  4  byte write enables; 4'b0000 means read.
- addr  in  32  byte address of the request.
- wdata  in  32  write data, little-endian byte lanes.
- rdata  out  32  read data; updated only on successful reads.
- ack  out  1  one-cycle pulse: transfer completed OK.
- err  out  1  one-cycle pulse: slave error or timeout.
- busy  out  1  high while a transfer is outstanding (state BUS).
- wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone cycle/strobe; always equal.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  word-aligned address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data from slave.
- wbm_ack_i, wbm_err_i  in  1 each  slave termination.

## Operation
- Two states: IDLE, BUS. Reset state IDLE.
- IDLE, stb=1: register addr, we, wdata; go to BUS. stb=0: stay.
- Registered outputs in BUS: wbm_cyc_o=wbm_stb_o=1; wbm_we_o=|we; wbm_sel_o=we for writes, 4'hF for reads; wbm_adr_o={addr[31:2],2'b00}; wbm_dat_o=wdata. Held stable for the entire BUS state.
- addr[1:0] is ignored; the core issues aligned accesses and expresses sub-word writes via we.
- BUS, wbm_err_i=1: go to IDLE, pulse err. wbm_err_i has priority over wbm_ack_i when both are high.
- BUS, wbm_ack_i=1 (err low): go to IDLE, pulse ack. Reads load rdata from wbm_dat_i on that same edge; writes leave rdata unchanged.
- Timeout: 16-bit counter cleared on IDLE→BUS and incremented each BUS cycle without termination. When the count reaches TIMEOUT_CYCLES-1 with no termination: go to IDLE, pulse err. A termination arriving in that same final cycle wins over the timeout (ack/err per slave).
- stb while busy=1 is a core protocol violation; it is ignored, with no queueing.
- In IDLE, wbm_cyc_o, wbm_stb_o, wbm_we_o, and wbm_sel_o are 0; wbm_adr_o/wbm_dat_o hold their last values.

## Timing
- Reset values: rdata=0, ack=0, err=0, busy=0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, counter=0.
- Reset asserted mid-transfer drops cyc/stb asynchronously and produces no ack/err.
- Cycle 0: stb high. Cycle 1: cyc/stb high. Slave acks in cycle N≥1. Cycle N+1: cyc/stb low, ack high, rdata valid. Minimum request-to-ack latency is 2 cycles.
- ack and err are never high together and are high for exactly one cycle.
- rdata stays valid from the ack pulse until the next successful read completes.
- Back-to-back: stb may be asserted in the ack/err cycle (state is IDLE). The next cyc_o then rises one cycle later, so cyc_o has at least one low cycle between transfers.
- Timeout with TIMEOUT_CYCLES=T: cyc_o high for exactly T cycles; err in cycle T+1 after cyc_o rose.

## Test plan
- Read: stb, we=0, addr=0x3000_8005, slave acks 1st cycle with 0xDEADBEEF → wbm_adr_o=0x3000_8004, sel=4'hF, we_o=0; ack and rdata=0xDEADBEEF 2 cycles after stb.
- Byte write: we=4'b0100, wdata=0x00AB0000, slave acks after 3 wait cycles → sel=4'b0100, we_o=1, cyc_o high 4 cycles; ack pulse; rdata keeps its previous value.
- Error priority: slave drives ack_i and err_i together → err=1, ack=0, rdata unchanged.
- Timeout with TIMEOUT_CYCLES=4, silent slave → cyc_o high exactly 4 cycles, then one err pulse; a next read completes normally. Repeat with TIMEOUT_CYCLES=0 and an ack after 300 cycles → ack, no err.
- Back-to-back: write then read with stb in the ack cycle → one-cycle cyc_o gap; both complete; stb pulses issued while busy produce no extra Wishbone cycle.
- Reset mid-read: rstn low while cyc_o=1 → cyc_o low immediately, no ack/err, all outputs at reset values.
